// File: rtl/sr_latch_ctrl.sv
// rtl/sr_latch_ctrl.sv - pulse sequencer that drives a NOR SR latch and verifies its state
module sr_latch_ctrl #(
    parameter int PULSE_W = 2,
    parameter int GUARD_W = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic set_req,
    input  logic clr_req,
    output logic S,
    output logic R,
    input  logic Q,
    input  logic Qbar,
    output logic busy,
    output logic done,
    output logic exp_q,
    output logic err
);

    typedef enum logic [1:0] {IDLE, PULSE, GUARD, CHECK} state_t;

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       prio, prio_nx;        // 1: set wins a tie, 0: clear wins
    logic       cmd_set, cmd_set_nx;
    logic       take_set;
    logic       s_nx, r_nx, busy_nx, done_nx, exp_nx, err_nx;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        prio_nx    = prio;
        cmd_set_nx = cmd_set;
        exp_nx     = exp_q;
        err_nx     = err;
        take_set   = 1'b0;

        case (state)
            IDLE: begin
                if (set_req || clr_req) begin
                    take_set = set_req && (!clr_req || prio);
                    if (set_req && clr_req) begin
                        prio_nx = ~prio;
                    end
                    cmd_set_nx = take_set;
                    exp_nx     = take_set;
                    state_nx   = PULSE;
                    cnt_nx     = 4'(PULSE_W - 1);
                end
            end
            PULSE: begin
                if (cnt == 4'd0) begin
                    if (GUARD_W == 0) begin
                        state_nx = CHECK;
                    end else begin
                        state_nx = GUARD;
                        cnt_nx   = 4'(GUARD_W - 1);
                    end
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            GUARD: begin
                if (cnt == 4'd0) begin
                    state_nx = CHECK;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            CHECK: begin
                err_nx   = err | (Q != exp_q) | (Qbar != ~exp_q);
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        s_nx    = (state_nx == PULSE) && cmd_set_nx;
        r_nx    = (state_nx == PULSE) && !cmd_set_nx;
        busy_nx = (state_nx != IDLE);
        done_nx = (state_nx == CHECK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            prio    <= 1'b0;
            cmd_set <= 1'b0;
            S       <= 1'b0;
            R       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            exp_q   <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            prio    <= prio_nx;
            cmd_set <= cmd_set_nx;
            S       <= s_nx;
            R       <= r_nx;
            busy    <= busy_nx;
            done    <= done_nx;
            exp_q   <= exp_nx;
            err     <= err_nx;
        end
    end

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// tb/tb_sr_latch_ctrl.sv - checks sr_latch_ctrl (guard 1 and guard 0) against a command-level model
module tb_sr_latch_ctrl;

    localparam int PW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic set_req = 1'b0;
    logic clr_req = 1'b0;

    logic s[2];
    logic r[2];
    logic q[2];
    logic qb[2];
    logic busy[2];
    logic done[2];
    logic expq[2];
    logic err[2];
    logic lq[2] = '{1'b0, 1'b0};
    logic qforce[2] = '{1'b0, 1'b0};

    int total = 0;
    int bad = 0;

    int   m_k[2];
    logic m_set[2];
    logic m_exp[2];
    logic m_prio[2];
    logic m_err[2];

    always #5 clk = ~clk;

    sr_latch_ctrl #(.PULSE_W(PW), .GUARD_W(1)) dut (
        .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req),
        .S(s[0]), .R(r[0]), .Q(q[0]), .Qbar(qb[0]),
        .busy(busy[0]), .done(done[0]), .exp_q(expq[0]), .err(err[0])
    );

    sr_latch_ctrl #(.PULSE_W(PW), .GUARD_W(0)) dut0 (
        .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req),
        .S(s[1]), .R(r[1]), .Q(q[1]), .Qbar(qb[1]),
        .busy(busy[1]), .done(done[1]), .exp_q(expq[1]), .err(err[1])
    );

    // Behavioural NOR latches, one per controller, with an optional stuck-low fault on Q.
    always @(s[0] or r[0]) begin
        if (s[0]) lq[0] = 1'b1;
        else if (r[0]) lq[0] = 1'b0;
    end
    always @(s[1] or r[1]) begin
        if (s[1]) lq[1] = 1'b1;
        else if (r[1]) lq[1] = 1'b0;
    end
    assign q[0]  = qforce[0] ? 1'b0 : lq[0];
    assign qb[0] = qforce[0] ? 1'b1 : ~lq[0];
    assign q[1]  = qforce[1] ? 1'b0 : lq[1];
    assign qb[1] = qforce[1] ? 1'b1 : ~lq[1];

    function automatic int cmd_len(input int i);
        return PW + ((i == 0) ? 1 : 0) + 1;
    endfunction

    // Command-level model: m_k is the cycle index within the current command, -1 when idle.
    task automatic model_step(input int i);
        if (rst) begin
            m_k[i] = -1; m_set[i] = 1'b0; m_exp[i] = 1'b0; m_prio[i] = 1'b0; m_err[i] = 1'b0;
        end else if (m_k[i] >= 0) begin
            if (m_k[i] == cmd_len(i) - 1) begin
                if (q[i] !== m_exp[i] || qb[i] !== ~m_exp[i]) m_err[i] = 1'b1;
                m_k[i] = -1;
            end else begin
                m_k[i] = m_k[i] + 1;
            end
        end else if (set_req || clr_req) begin
            if (set_req && clr_req) begin
                m_set[i]  = m_prio[i];
                m_prio[i] = ~m_prio[i];
            end else begin
                m_set[i] = set_req;
            end
            m_exp[i] = m_set[i];
            m_k[i]   = 0;
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic check(input string name, input logic act, input logic req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        total = total + 1;
        if (act != req) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        #2;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("S[%0d]", i), s[i], m_k[i] >= 0 && m_k[i] < PW && m_set[i]);
            check($sformatf("R[%0d]", i), r[i], m_k[i] >= 0 && m_k[i] < PW && !m_set[i]);
            check($sformatf("busy[%0d]", i), busy[i], m_k[i] >= 0);
            check($sformatf("done[%0d]", i), done[i], m_k[i] == cmd_len(i) - 1);
            check($sformatf("exp_q[%0d]", i), expq[i], m_exp[i]);
            check($sformatf("err[%0d]", i), err[i], m_err[i]);
            check($sformatf("no_SR_overlap[%0d]", i), s[i] & r[i], 1'b0);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    logic [1:0] pats[16] = '{2'b01, 2'b00, 2'b11, 2'b11, 2'b10, 2'b00, 2'b11, 2'b01,
                             2'b10, 2'b10, 2'b11, 2'b00, 2'b01, 2'b11, 2'b10, 2'b11};

    initial begin
        int n;
        tick(); tick();
        check("rst_S", s[0], 1'b0);
        check("rst_busy", busy[0], 1'b0);
        check("rst_exp_q", expq[0], 1'b0);
        check("rst_err", err[0], 1'b0);

        // set right after reset release
        rst = 1'b0; set_req = 1'b1; tick(); set_req = 1'b0;
        check("set_k0_S", s[0], 1'b1);
        check("set_k0_busy", busy[0], 1'b1);
        check("set_k0_exp_q", expq[0], 1'b1);
        tick();
        check("set_k1_S", s[0], 1'b1);
        tick();
        check("set_guard_S", s[0], 1'b0);
        check("set_guard_busy", busy[0], 1'b1);
        check("g0_done_after_pulse", done[1], 1'b1);
        tick();
        check("set_done", done[0], 1'b1);
        check("g0_idle", busy[1], 1'b0);
        tick();
        check("set_idle_busy", busy[0], 1'b0);
        check("set_latch_q", q[0], 1'b1);
        check("set_err", err[0], 1'b0);

        // simultaneous requests: clear first, then set
        rst = 1'b1; tick(); rst = 1'b0;
        set_req = 1'b1; clr_req = 1'b1; tick();
        check("tie1_R", r[0], 1'b1);
        check("tie1_exp_q", expq[0], 1'b0);
        repeat (5) tick();
        check("tie2_S", s[0], 1'b1);
        check("tie2_exp_q", expq[0], 1'b1);
        set_req = 1'b0; clr_req = 1'b0;
        repeat (5) tick();

        // clear pulsed while busy is dropped
        set_req = 1'b1; tick(); set_req = 1'b0; tick();
        clr_req = 1'b1; tick(); clr_req = 1'b0;
        repeat (4) tick();
        check("busy_clr_ignored", expq[0], 1'b1);

        // held clear accepted on first idle cycle after done
        set_req = 1'b1; tick(); set_req = 1'b0; clr_req = 1'b1;
        n = 0;
        while (expq[0] == 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_int("held_clr_latency", n, 5);
        clr_req = 1'b0;
        repeat (5) tick();

        // Q stuck low during a set command
        qforce[0] = 1'b1;
        set_req = 1'b1; tick(); set_req = 1'b0;
        repeat (4) tick();
        check("err_set", err[0], 1'b1);
        check("err_other_clean", err[1], 1'b0);
        qforce[0] = 1'b0;
        clr_req = 1'b1; tick(); clr_req = 1'b0; repeat (4) tick();
        set_req = 1'b1; tick(); set_req = 1'b0; repeat (5) tick();
        check("err_sticky", err[0], 1'b1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("err_cleared", err[0], 1'b0);

        // reset in the second pulse cycle
        set_req = 1'b1; tick(); set_req = 1'b0; tick();
        check("abort_pulse2_S", s[0], 1'b1);
        rst = 1'b1; tick();
        check("abort_S", s[0], 1'b0);
        check("abort_busy", busy[0], 1'b0);
        check("abort_exp_q", expq[0], 1'b0);
        check("abort_done", done[0], 1'b0);
        rst = 1'b0;
        repeat (4) tick();

        // mixed request patterns
        for (int i = 0; i < 48; i++) begin
            {set_req, clr_req} = pats[i % 16];
            tick();
        end
        set_req = 1'b0; clr_req = 1'b0;
        repeat (6) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sr_latch_ctrl.md
SR_LATCH_CTRL -- requirements
Module: sr_latch_ctrl

Interface
REQ-001 The block SHALL have parameter PULSE_W, default 2: number of cycles S or R is held high per command, legal range 1..15.
REQ-002 The block SHALL have parameter GUARD_W, default 1: number of cycles S and R are both held low after a pulse, legal range 0..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port set_req, input, 1 bit: request to store 1 in the latch.
REQ-006 The block SHALL have port clr_req, input, 1 bit: request to store 0 in the latch.
REQ-007 The block SHALL have port S, output, 1 bit: set drive to the NOR SR latch, registered.
REQ-008 The block SHALL have port R, output, 1 bit: reset drive to the latch, registered.
REQ-009 The block SHALL have port Q, input, 1 bit: latch true output.
REQ-010 The block SHALL have port Qbar, input, 1 bit: latch complement output.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a command is in progress.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-013 The block SHALL have port exp_q, output, 1 bit: the value the latch is commanded to hold.
REQ-014 The block SHALL have port err, output, 1 bit: sticky latch-mismatch flag.

Function
REQ-015 The block SHALL implement FSM states IDLE, PULSE, GUARD and CHECK, all outputs registered.
REQ-016 In IDLE with busy=0, a request sampled high at a rising edge SHALL be accepted; the next state is PULSE.
REQ-017 Requests sampled while busy=1 SHALL be ignored, not queued; requesters hold the request until accepted.
REQ-018 When set_req and clr_req are both high in IDLE, a round-robin priority bit SHALL pick the winner and then toggle to favour the loser; the loser is not latched.
REQ-019 The priority bit SHALL toggle only on a simultaneous-request grant; single requests SHALL leave it unchanged.
REQ-020 PULSE SHALL last exactly PULSE_W cycles, with S=1 for set or R=1 for clear; exp_q SHALL update to the commanded value on entry to PULSE.
REQ-021 GUARD SHALL last GUARD_W cycles with S=R=0; when GUARD_W=0, PULSE SHALL go directly to CHECK.
REQ-022 CHECK SHALL last 1 cycle with S=R=0 and done=1, then return to IDLE.
REQ-023 In CHECK, err SHALL be set if Q != exp_q or Qbar != ~exp_q; err clears only on rst.
REQ-024 busy SHALL be high in every PULSE, GUARD and CHECK cycle, for PULSE_W+GUARD_W+1 cycles per command.
REQ-025 The next command SHALL be accepted no earlier than the first IDLE cycle after CHECK.
REQ-026 S and R SHALL never both be 1 in any cycle, including during reset and under any request pattern.
REQ-027 A request matching the current exp_q SHALL still execute the full sequence, keeping latency deterministic.
REQ-028 A single 4-bit down-counter SHALL time PULSE and GUARD, reloaded on each state entry.

Reset
REQ-029 While rst=1 at a rising edge, the block SHALL set state=IDLE, S=0, R=0, busy=0, done=0, exp_q=0, err=0, and priority to clear-first.
REQ-030 Reset asserted mid-command SHALL abort the command: S/R low at the next edge, no done pulse, and exp_q=0.
REQ-031 A request high in the first cycle after rst deasserts SHALL be accepted normally.

Verification (PULSE_W=2, GUARD_W=1)
REQ-032 Scenario: set_req pulse in IDLE -> S=1 for 2 cycles, S=R=0 for 1 cycle, then done=1 for 1 cycle; busy high 4 cycles; exp_q=1; with a real latch, Q=1, Qbar=0, err=0.
REQ-033 Scenario: set_req=clr_req=1 held for 2 commands after reset -> first R pulse (exp_q=0), then S pulse (exp_q=1); no cycle with S=R=1.
REQ-034 Scenario: clr_req pulsed while busy -> ignored; held clr_req is accepted on the first IDLE cycle after done.
REQ-035 Scenario: Q forced to 0 during a set command's CHECK -> err=1, and err stays 1 through later good commands until rst.
REQ-036 Scenario: rst asserted in the second PULSE cycle -> next edge S=0, busy=0, exp_q=0, and no done pulse.
REQ-037 Scenario: GUARD_W=0, set_req -> busy for 3 cycles, and done in the cycle after the last S=1 cycle.
